// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue unit and the arithmetic unit it drives:
// opcode/operand-select encodings, instruction field layout and FSM states.
package issue_unit_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 3;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB   = 30;
  localparam int MOVI_LSB = 28;
  localparam int RD_LSB   = 25;
  localparam int RA_LSB   = 22;
  localparam int RB_LSB   = 19;
  localparam int RSVD_LSB = 16;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    MOVI_REG_B = 2'd0,
    MOVI_MEM   = 2'd1,
    MOVI_IMM   = 2'd2,
    MOVI_ZERO  = 2'd3
  } movi_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    op_e                op;
    movi_e              movi;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  ra;
    logic [REG_AW-1:0]  rb;
    logic [2:0]         rsvd;
    logic [15:0]        imm;
  } instr_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/issue_unit_regfile.sv
// Architectural register file: one write port, two operand read ports and a
// debug read port. Row 0 has no storage and always reads as zero.
module regfile
  import issue_unit_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [XLEN-1:0]   ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [XLEN-1:0]   rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] rows [NREGS];

  assign rows[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_row
      logic [XLEN-1:0] q_reg;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          q_reg <= '0;
        end else if (we && (waddr == REG_AW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign rows[gi] = q_reg;
    end
  endgenerate

  // Addresses beyond the implemented rows read as zero
  assign ra_data  = (int'(ra_addr)  < NREGS) ? rows[ra_addr]  : '0;
  assign rb_data  = (int'(rb_addr)  < NREGS) ? rows[rb_addr]  : '0;
  assign dbg_data = (int'(dbg_addr) < NREGS) ? rows[dbg_addr] : '0;

endmodule

// File: rtl/issue_unit.sv
// Single-issue front end: accepts one instruction, hands latched operands to
// the arithmetic unit, waits (bounded) for the result and retires it.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int NREGS   = 8,
  parameter int TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_INSTR,
  input  logic [31:0] IN_MEM,
  output logic        AU_ACT,
  output logic [1:0]  AU_OP_CODE,
  output logic [1:0]  AU_MOVI,
  output logic [31:0] AU_REG_A,
  output logic [31:0] AU_REG_B,
  output logic [31:0] AU_MEM,
  output logic [31:0] AU_IMM,
  input  logic [31:0] AU_DATA,
  input  logic        AU_DATA_VALID,
  output logic        WB_VALID,
  output logic [2:0]  WB_ADDR,
  output logic [31:0] WB_DATA,
  output logic        ERR,
  input  logic [2:0]  DBG_ADDR,
  output logic [31:0] DBG_DATA
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  instr_t            instr;
  logic              unused_rsvd;

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              accept, capture, timeout;

  op_e               op_reg;
  movi_e             movi_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [XLEN-1:0]   reg_a_reg, reg_b_reg, mem_reg, imm_reg;

  logic              wb_valid_reg;
  logic [REG_AW-1:0] wb_addr_reg;
  logic [XLEN-1:0]   wb_data_reg;
  logic              err_reg;

  logic [XLEN-1:0]   rf_ra_data, rf_rb_data;

  assign instr       = instr_t'(IN_INSTR);
  assign unused_rsvd = ^instr.rsvd;

  regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .we       (capture),
    .waddr    (rd_reg),
    .wdata    (AU_DATA),
    .ra_addr  (instr.ra),
    .ra_data  (rf_ra_data),
    .rb_addr  (instr.rb),
    .rb_data  (rf_rb_data),
    .dbg_addr (DBG_ADDR),
    .dbg_data (DBG_DATA)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    accept        = 1'b0;
    capture       = 1'b0;
    timeout       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (IN_VALID) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next    = ST_WAIT;
        wait_cnt_next = '0;
      end
      ST_WAIT: begin
        if (AU_DATA_VALID) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th empty WAIT cycle: abandon the instruction
          timeout       = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Operands are captured once at acceptance and held for the whole flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_reg    <= OP_ADD;
      movi_reg  <= MOVI_REG_B;
      rd_reg    <= '0;
      reg_a_reg <= '0;
      reg_b_reg <= '0;
      mem_reg   <= '0;
      imm_reg   <= '0;
    end else if (accept) begin
      op_reg    <= instr.op;
      movi_reg  <= instr.movi;
      rd_reg    <= instr.rd;
      reg_a_reg <= rf_ra_data;
      reg_b_reg <= rf_rb_data;
      mem_reg   <= IN_MEM;
      imm_reg   <= sext_imm(instr.imm);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      wb_valid_reg <= capture;
      if (capture) begin
        wb_addr_reg <= rd_reg;
        wb_data_reg <= AU_DATA;
      end
      if (timeout) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign IN_READY   = (state_reg == ST_IDLE);
  assign AU_ACT     = (state_reg == ST_ISSUE);
  assign AU_OP_CODE = op_reg;
  assign AU_MOVI    = movi_reg;
  assign AU_REG_A   = reg_a_reg;
  assign AU_REG_B   = reg_b_reg;
  assign AU_MEM     = mem_reg;
  assign AU_IMM     = imm_reg;
  assign WB_VALID   = wb_valid_reg;
  assign WB_ADDR    = wb_addr_reg;
  assign WB_DATA    = wb_data_reg;
  assign ERR        = err_reg;

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameter NREGS, default 8, number of 32-bit architectural registers; r0 reads as zero.
REQ-002 Parameter TIMEOUT, default 8, maximum cycles spent in WAIT before an error abort.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 IN_VALID  in  1  instruction offer.
REQ-006 IN_READY  out  1  instruction accepted on an edge where IN_VALID and IN_READY are both 1.
REQ-007 IN_INSTR  in  32  [31:30] op, [29:28] movi, [27:25] rd, [24:22] ra, [21:19] rb, [18:16] reserved, [15:0] imm.
REQ-008 IN_MEM  in  32  memory operand, sampled together with IN_INSTR.
REQ-009 AU_ACT  out  1  start pulse to the arithmetic unit.
REQ-010 AU_OP_CODE, AU_MOVI  out  2 each  operator code and second-operand select.
REQ-011 AU_REG_A, AU_REG_B, AU_MEM, AU_IMM  out  32 each  operands.
REQ-012 AU_DATA  in  32  arithmetic unit result.
REQ-013 AU_DATA_VALID  in  1  result valid strobe.
REQ-014 WB_VALID  out  1  one-cycle pulse indicating a retired instruction.
REQ-015 WB_ADDR  out  3  destination register of the retired instruction.
REQ-016 WB_DATA  out  32  result of the retired instruction.
REQ-017 ERR  out  1  sticky timeout flag.
REQ-018 DBG_ADDR  in  3  debug read address.
REQ-019 DBG_DATA  out  32  combinational read of regs[DBG_ADDR]; returns 0 for address 0.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, ISSUE and WAIT, with exactly one instruction in flight.
REQ-021 IN_READY SHALL be 1 only in IDLE; on acceptance the FSM SHALL move to ISSUE.
REQ-022 On acceptance, the block SHALL latch: op, movi, rd, regs[ra] and regs[rb] (r0 = 0), IN_MEM, and imm sign-extended to 32 bits.
REQ-023 AU_* operand and control outputs SHALL be driven from the latched values and SHALL remain stable from ISSUE until the result is captured.
REQ-024 AU_ACT SHALL be 1 for exactly the single ISSUE cycle; the next state SHALL be WAIT, with the wait counter cleared.
REQ-025 In WAIT, an edge with AU_DATA_VALID=1 SHALL:
 - write AU_DATA to regs[rd], discarding the write when rd=0;
 - assert WB_VALID for the next cycle, with WB_ADDR=rd and WB_DATA=AU_DATA;
 - return the FSM to IDLE.
REQ-026 AU_DATA_VALID seen in IDLE or ISSUE SHALL be ignored.
REQ-027 Latency from acceptance edge E0 to the capture edge SHALL be E0+2 for ADD, SUB and DIV, and E0+5 for MUL.
REQ-028 Sustained throughput SHALL be one instruction per 3 cycles for non-MUL operations and one per 6 cycles for MUL.
REQ-029 WAIT counter behaviour:
 - the counter SHALL increment on each WAIT cycle without a result;
 - on reaching TIMEOUT, the block SHALL set ERR, skip the register write, skip WB_VALID and go to IDLE.
REQ-030 ERR SHALL be cleared only by reset; the block SHALL continue accepting instructions while ERR=1.
REQ-031 The reserved field [18:16] SHALL be ignored.
REQ-032 When rd equals ra or rb of the next instruction, the next instruction SHALL read the updated value (write completes before IN_READY rises).

Reset
REQ-033 With RST_N=0, the block SHALL immediately set:
 - FSM to IDLE;
 - all registers to 0;
 - AU_ACT=0, WB_VALID=0, ERR=0, WB_ADDR=0, WB_DATA=0;
 - latched operands to 0.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight instruction with no writeback; IN_READY SHALL be 1 on the first edge after RST_N rises.

Structure
REQ-035 The opcode enum (ADD=0, SUB=1, MUL=2, DIV=3), the movi encoding (REG_B=0, MEM=1, IMM=2, ZERO=3) and the instruction field positions SHALL reside in a shared package also used by the arithmetic unit.
REQ-036 The register file SHALL be a sub-module regfile, with one write port, two read ports plus a debug read port, and r0 hardwired to zero.

Verification
REQ-037 Scenario: r1=5, r2=3, ADD rd=3 ra=1 rb=2 movi=0 -> WB_VALID at E0+3, WB_DATA=8, regs[3]=8.
REQ-038 Scenario: MUL rd=4 ra=1 movi=2 imm=0xFFFF -> AU_IMM=0xFFFFFFFF, WB_DATA=0xFFFFFFFB, capture edge at E0+5, operands held stable throughout.
REQ-039 Scenario: DIV ra=1 movi=3 -> WB_DATA=0; ADD rd=0 -> WB_VALID=1 and DBG_DATA(0)=0.
REQ-040 Scenario: AU_DATA_VALID forced to 0 -> ERR=1 after 8 WAIT cycles, no WB_VALID, and the next instruction completes normally.
REQ-041 Scenario: RST_N pulsed low during a MUL WAIT -> no writeback, all outputs 0, IN_READY=1 on the first edge after release.
REQ-042 Scenario: back-to-back ADD r3=r1+r2 then SUB r4=r3-r1 -> regs[4]=3, with IN_READY low during ISSUE and WAIT.
